// File: rtl/shift_left_iterative_if.sv
// Request/response bundle for the iterative left shifter: operand handshake in, result handshake out.
interface shift_left_iterative_if #(
  parameter int CNT_W = 4,
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] In;
  logic [CNT_W-1:0] Cnt;
  logic             Op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Out;
  logic             busy;

  modport master (
    output in_valid, In, Cnt, Op, out_ready,
    input  in_ready, out_valid, Out, busy
  );

  modport slave (
    input  in_valid, In, Cnt, Op, out_ready,
    output in_ready, out_valid, Out, busy
  );
endinterface

// File: rtl/shift_left_iterative.sv
// Multi-cycle SLL/ROL unit: one log-shifter stage (1, 2, 4, 8, ...) per clock, fixed CNT_W-cycle latency.
//   state | meaning
//   IDLE  | ready for a request; Out holds the last result
//   SHIFT | applying stage stage_q to work_q
//   DONE  | result valid on Out, waiting for out_ready
module shift_left_iterative #(
  parameter int CNT_W = 4,
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  shift_left_iterative_if.slave bus
);

  localparam int STG_W = (CNT_W > 1) ? $clog2(CNT_W) : 1;
  localparam logic [STG_W-1:0] LAST_STAGE = STG_W'(CNT_W - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [STG_W-1:0] stage_q, stage_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] out_q, out_d;

  logic [CNT_W:0]   shamt;
  logic [WIDTH-1:0] sll_val;
  logic [WIDTH-1:0] rol_val;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      stage_q <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      out_q   <= out_d;
    end
  end

  // Stage shift amount is 2**stage, never zero, so the rotate spill term is always well-defined.
  always_comb begin
    shamt   = {{CNT_W{1'b0}}, 1'b1} << stage_q;
    sll_val = work_q << shamt;
    rol_val = sll_val | (work_q >> (WIDTH - int'(shamt)));
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    out_d   = out_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          work_d  = bus.In;
          cnt_d   = bus.Cnt;
          op_d    = bus.Op;
          stage_d = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt_q[stage_q]) begin
          work_d = op_q ? rol_val : sll_val;
        end
        stage_d = stage_q + STG_W'(1);
        if (stage_q == LAST_STAGE) begin
          out_d   = work_d;
          stage_d = '0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.in_ready  = (state_q == ST_IDLE);
  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.Out       = out_q;

endmodule

// File: tb/tb_shift_left_iterative.sv
// Self-checking bench for shift_left_iterative: directed spec vectors, handshake corners, reset, random traffic.
module tb_shift_left_iterative;
  localparam int CNT_W = 4;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  shift_left_iterative_if #(.CNT_W(CNT_W), .WIDTH(WIDTH)) bus ();

  shift_left_iterative #(.CNT_W(CNT_W), .WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Rotate = low half of the widened shift OR'd with the bits that spilled into the high half.
  function automatic logic [WIDTH-1:0] ref_model(input logic [WIDTH-1:0] a, input int n, input logic op);
    logic [2*WIDTH-1:0] wide;
    wide = {{WIDTH{1'b0}}, a} << n;
    if (!op) return wide[WIDTH-1:0];
    return wide[WIDTH-1:0] | wide[2*WIDTH-1:WIDTH];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input logic [WIDTH-1:0] a, input logic [CNT_W-1:0] n, input logic op,
                         output logic [WIDTH-1:0] res, output int lat);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL run_one_in_ready got %b want 1", bus.in_ready);
    end
    bus.In = a;
    bus.Cnt = n;
    bus.Op = op;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.In = WIDTH'($urandom);
    bus.Cnt = CNT_W'($urandom);
    bus.Op = 1'($urandom);
    lat = 0;
    while (bus.out_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    res = bus.Out;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.Out !== '0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b busy=%b out=%h want 1 0 0 0000",
               bus.in_ready, bus.out_valid, bus.busy, bus.Out);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_hold got rdy=%b busy=%b want 1 0", bus.in_ready, bus.busy);
    end
  endtask

  task automatic test_directed();
    logic [WIDTH-1:0] vin [7] = '{16'h00F1, 16'h8001, 16'hABCD, 16'h1234, 16'hFFFF, 16'h8000, 16'h0001};
    logic [CNT_W-1:0] vcnt[7] = '{4'd4, 4'd1, 4'd8, 4'd0, 4'd15, 4'd1, 4'd15};
    logic             vop [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [WIDTH-1:0] vexp[7] = '{16'h0F10, 16'h0003, 16'hCDAB, 16'h1234, 16'h8000, 16'h0000, 16'h8000};
    logic [WIDTH-1:0] res;
    int lat;
    for (int i = 0; i < 7; i++) begin
      run_one(vin[i], vcnt[i], vop[i], res, lat);
      checks++;
      if (res !== vexp[i]) begin
        errors++;
        $display("FAIL directed_out[%0d] got %h want %h", i, res, vexp[i]);
      end
      checks++;
      if (lat !== 4) begin
        errors++;
        $display("FAIL directed_latency[%0d] got %0d want 4", i, lat);
      end
      consume();
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.Out !== vexp[i]) begin
        errors++;
        $display("FAIL directed_after_accept[%0d] got rdy=%b vld=%b out=%h want 1 0 %h",
                 i, bus.in_ready, bus.out_valid, bus.Out, vexp[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] exp_v;
    int lat;
    exp_v = ref_model(16'h1357, 3, 1'b1);
    run_one(16'h1357, 4'd3, 1'b1, res, lat);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.Out !== exp_v || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d] got vld=%b out=%h rdy=%b want 1 %h 0",
                 i, bus.out_valid, bus.Out, bus.in_ready, exp_v);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_no_bypass got in_ready=%b want 0", bus.in_ready);
    end
    tick();
    bus.out_ready = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_release got rdy=%b vld=%b busy=%b want 1 0 0",
               bus.in_ready, bus.out_valid, bus.busy);
    end
  endtask

  task automatic test_ignore();
    int n;
    bus.In = 16'h00F1;
    bus.Cnt = 4'd4;
    bus.Op = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      bus.In = WIDTH'($urandom);
      bus.Cnt = CNT_W'($urandom);
      bus.Op = 1'($urandom);
      tick();
      n++;
    end
    tick();
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.Out !== 16'h0F10 || bus.out_valid !== 1'b1 || n !== 4) begin
      errors++;
      $display("FAIL ignore_result got out=%h vld=%b lat=%0d want 0f10 1 4", bus.Out, bus.out_valid, n);
    end
    consume();
    tick();
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.Out !== 16'h0F10) begin
      errors++;
      $display("FAIL ignore_nothing_queued got vld=%b busy=%b out=%h want 0 0 0f10",
               bus.out_valid, bus.busy, bus.Out);
    end
  endtask

  task automatic test_reset_mid();
    logic [WIDTH-1:0] res;
    int lat;
    bus.In = 16'hFFFF;
    bus.Cnt = 4'd15;
    bus.Op = 1'b0;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.Out !== '0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got vld=%b out=%h rdy=%b busy=%b want 0 0000 1 0",
               bus.out_valid, bus.Out, bus.in_ready, bus.busy);
    end
    run_one(16'hABCD, 4'd8, 1'b1, res, lat);
    checks++;
    if (res !== 16'hCDAB || lat !== 4) begin
      errors++;
      $display("FAIL reset_mid_recover got out=%h lat=%0d want cdab 4", res, lat);
    end
    consume();
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] a;
    logic [CNT_W-1:0] n;
    logic             op;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] exp_v;
    int lat;
    int stall;
    for (int i = 0; i < 1000; i++) begin
      a = WIDTH'($urandom);
      n = CNT_W'($urandom_range(0, WIDTH - 1));
      op = 1'($urandom);
      exp_v = ref_model(a, int'(n), op);
      run_one(a, n, op, res, lat);
      checks++;
      if (res !== exp_v || lat !== 4) begin
        errors++;
        $display("FAIL random[%0d] in=%h cnt=%0d op=%b got out=%h lat=%0d want %h 4",
                 i, a, n, op, res, lat, exp_v);
      end
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) tick();
      if (stall > 0) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.Out !== exp_v) begin
          errors++;
          $display("FAIL random_stall[%0d] got vld=%b out=%h want 1 %h", i, bus.out_valid, bus.Out, exp_v);
        end
      end
      consume();
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.In = '0;
    bus.Cnt = '0;
    bus.Op = 1'b0;
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    test_reset();
    test_directed();
    test_stall();
    test_ignore();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
